// File: rtl/avalon_st_pkg.sv
// Shared helpers for the Avalon-ST packet FIFO: empty-field width and
// parameter legality check used at elaboration.
package avalon_st_pkg;

    // Width of the empty field: enough bits to count symbols, never zero.
    function automatic int ew_bits(input int symbols);
        int w;
        w = $clog2(symbols);
        return (w < 1) ? 1 : w;
    endfunction

    // Legal combinations: latency 0..4, allowance covers the in-flight
    // window, and the allowance leaves at least one usable slot.
    function automatic bit params_ok(input int depth, input int latency,
                                     input int allowance);
        return (depth >= 1) && (latency >= 0) && (latency <= 4) &&
               (allowance >= latency) && (allowance < (1 << depth));
    endfunction

endpackage

// File: rtl/avalon_st_fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with
// read enable. The read register is cleared by reset; the array is not.
module avalon_st_fifo_mem #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rd_data_q;

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    // Registered read; holds its value when not enabled.
    always_ff @(posedge clk) begin
        if (rst)          rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/avalon_st_pkt_fifo.sv
// Single-clock Avalon-ST packet FIFO. Sink side honours a configurable
// ready latency using a held-back allowance of free slots; source side is
// latency-0 show-ahead fed straight from the RAM's registered read port.
module avalon_st_pkt_fifo
    import avalon_st_pkg::*;
#(
    parameter int DATABITS_PER_SYMBOL = 8,
    parameter int SYMBOLS_PER_BEAT    = 4,
    parameter int DEPTH               = 4,
    parameter int READY_LATENCY       = 1,
    parameter int READY_ALLOWANCE     = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL-1:0] data_wr,
    input  logic                                            valid_wr,
    input  logic                                            sop_wr,
    input  logic                                            eop_wr,
    input  logic [ew_bits(SYMBOLS_PER_BEAT)-1:0]            empty_wr,
    output logic                                            ready_wr,
    output logic [SYMBOLS_PER_BEAT*DATABITS_PER_SYMBOL-1:0] data_rd,
    output logic                                            valid_rd,
    output logic                                            sop_rd,
    output logic                                            eop_rd,
    output logic [ew_bits(SYMBOLS_PER_BEAT)-1:0]            empty_rd,
    input  logic                                            ready_rd,
    output logic [DEPTH:0]                                  usedw,
    output logic                                            overflow
);

    localparam int WIDTH = SYMBOLS_PER_BEAT * DATABITS_PER_SYMBOL;
    localparam int EW    = ew_bits(SYMBOLS_PER_BEAT);
    localparam int SLOTS = 2 ** DEPTH;
    localparam logic [DEPTH:0] FULL_CNT  = (DEPTH+1)'(SLOTS);
    localparam logic [DEPTH:0] ALLOW_CNT = (DEPTH+1)'(READY_ALLOWANCE);

    if (!params_ok(DEPTH, READY_LATENCY, READY_ALLOWANCE)) begin : g_param_err
        $error("avalon_st_pkt_fifo: READY_LATENCY must be 0..4 and <= READY_ALLOWANCE < 2**DEPTH");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sop;
        logic             eop;
        logic [EW-1:0]    empty;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    logic [DEPTH-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
    logic [DEPTH:0]   count_q, count_d;
    logic             rst_q, valid_q, valid_d, overflow_q;
    logic             permitted, hist_live;
    logic             wr_acc, rd_acc, drop;
    beat_t            wr_beat, rd_beat;
    logic [BEAT_W-1:0] rd_bits;

    // Ready comes only from registered state, so it never depends on inputs.
    assign ready_wr = !rst_q && ((FULL_CNT - count_q) > ALLOW_CNT);

    if (READY_LATENCY == 0) begin : g_rl0
        assign permitted = ready_wr;
        assign hist_live = 1'b1;
    end else begin : g_rln
        logic [READY_LATENCY-1:0] rdy_hist_q, live_q;

        // Ready history: a beat at cycle t is allowed if ready was high
        // READY_LATENCY cycles earlier. live_q marks history entries that
        // were sampled after reset, so stale in-flight beats drop silently.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdy_hist_q <= '0;
                live_q     <= '0;
            end else begin
                rdy_hist_q <= READY_LATENCY'({rdy_hist_q, ready_wr});
                live_q     <= READY_LATENCY'({live_q, 1'b1});
            end
        end

        assign permitted = rdy_hist_q[READY_LATENCY-1];
        assign hist_live = live_q[READY_LATENCY-1];
    end

    assign wr_acc  = valid_wr && permitted;
    assign drop    = valid_wr && !permitted && hist_live;
    assign rd_acc  = valid_q && ready_rd;
    assign rd_addr = rd_ptr_q + DEPTH'(rd_acc);
    assign wr_beat = {data_wr, sop_wr, eop_wr, empty_wr};

    // Next head is presentable if an entry written before this edge remains
    // after any pop; a write landing on this same edge shows a cycle later.
    assign valid_d = count_q > (DEPTH+1)'(rd_acc);

    // Fill count: write-only up, read-only down, both cancel.
    always_comb begin
        count_d = count_q;
        if (wr_acc && !rd_acc)      count_d = count_q + (DEPTH+1)'(1);
        else if (!wr_acc && rd_acc) count_d = count_q - (DEPTH+1)'(1);
    end

    // Pointers, count, output valid and sticky overflow.
    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + DEPTH'(1);
            rd_ptr_q   <= rd_addr;
            count_q    <= count_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_q | drop;
        end
    end

    avalon_st_fifo_mem #(
        .AW (DEPTH),
        .DW (BEAT_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_beat),
        .rd_en_i   (valid_d),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_bits)
    );

    assign rd_beat  = beat_t'(rd_bits);
    assign data_rd  = rd_beat.data;
    assign sop_rd   = rd_beat.sop;
    assign eop_rd   = rd_beat.eop;
    assign empty_rd = rd_beat.empty;
    assign valid_rd = valid_q;
    assign usedw    = count_q;
    assign overflow = overflow_q;

endmodule
